// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin arbiter.
// Optional feature macro: RR_ARB4WAY16_LOCK_EN (adds the LOCKED state label).
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef logic [1:0] req_idx_t;

  // Output-slot occupancy; LOCKED names the packet-lock condition in lock builds.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1
`ifdef RR_ARB4WAY16_LOCK_EN
    ,
    LOCKED = 2'd2
`endif
  } state_t;

  // One-hot decode of a requester index.
  function automatic logic [NUM_REQ-1:0] idx2onehot(req_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/Mux4Way16.sv
// Four-way 16-bit word multiplexer (existing datapath block).
// Optional feature macro: none (RR_ARB4WAY16_LOCK_EN does not affect this file).
module Mux4Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] out
);

  // Select one of four words by sel.
  always_comb begin
    out = a;
    case (sel)
      2'd0:    out = a;
      2'd1:    out = b;
      2'd2:    out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first valid requester at or after ptr.
// Optional feature macro: none (RR_ARB4WAY16_LOCK_EN does not affect this file).
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] in_valid,
  input  req_idx_t           ptr,
  output req_idx_t           grant,
  output logic               any_valid
);

  req_idx_t idx;

  // Scan from the farthest offset back to ptr so the nearest valid index wins last.
  always_comb begin
    grant = ptr;
    idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + req_idx_t'(k);
      if (in_valid[idx]) grant = idx;
    end
  end

  assign any_valid = |in_valid;

endmodule

// File: rtl/rr_arb4way16.sv
// Four-requester round-robin arbiter with a registered 16-bit output slot.
// Optional feature macro: RR_ARB4WAY16_LOCK_EN adds in_last/out_last and a
// packet lock that holds the grant on one requester until its last beat.
module rr_arb4way16
  import arb_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [WIDTH-1:0]   in_data_a,
  input  logic [WIDTH-1:0]   in_data_b,
  input  logic [WIDTH-1:0]   in_data_c,
  input  logic [WIDTH-1:0]   in_data_d,
`ifdef RR_ARB4WAY16_LOCK_EN
  input  logic [3:0]         in_last,
  output logic               out_last,
`endif
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  state_t            state_q, state_d;
  req_idx_t          ptr_q;
  logic [WIDTH-1:0]  data_p1;
  req_idx_t          sel_p1;
  logic [WIDTH-1:0]  mux_p0;
  logic [3:0]        pick_valid;
  req_idx_t          pick_ptr;
  req_idx_t          grant;
  logic              any_valid;
  logic              take;
  logic              xfer;

`ifdef RR_ARB4WAY16_LOCK_EN
  logic              lock_q;
  req_idx_t          lock_idx_q;
  logic              last_p1;

  // While locked only the owning requester is visible to the picker.
  assign pick_valid = lock_q ? (in_valid & idx2onehot(lock_idx_q)) : in_valid;
  assign pick_ptr   = lock_q ? lock_idx_q : ptr_q;
  assign out_last   = last_p1;
`else
  assign pick_valid = in_valid;
  assign pick_ptr   = ptr_q;
`endif

  rr_pick4 u_pick (
    .in_valid  (pick_valid),
    .ptr       (pick_ptr),
    .grant     (grant),
    .any_valid (any_valid)
  );

  Mux4Way16 u_mux (
    .a   (in_data_a),
    .b   (in_data_b),
    .c   (in_data_c),
    .d   (in_data_d),
    .sel (grant),
    .out (mux_p0)
  );

  // The slot can accept a new beat when empty or draining this cycle;
  // rst_n gates ready so no handshake completes while reset is held.
  assign take     = (state_q == EMPTY) || out_ready;
  assign xfer     = take && any_valid && rst_n;
  assign in_ready = xfer ? idx2onehot(grant) : 4'b0000;

  // Output-slot next state: fill on transfer, empty on drain without refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (xfer) state_d = FULL;
      FULL: begin
        if (xfer)           state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // ---- stage p0 -> p1: register the granted word, index and pointer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      data_p1 <= '0;
      sel_p1  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        data_p1 <= mux_p0;
        sel_p1  <= grant;
`ifndef RR_ARB4WAY16_LOCK_EN
        ptr_q   <= grant + 2'd1;
`else
        if (in_last[grant]) ptr_q <= grant + 2'd1;
`endif
      end
    end
  end

`ifdef RR_ARB4WAY16_LOCK_EN
  // Lock tracking: hold the grant on a requester until its last beat transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      last_p1    <= 1'b0;
    end else if (xfer) begin
      last_p1    <= in_last[grant];
      lock_q     <= !in_last[grant];
      lock_idx_q <= grant;
    end
  end
`endif

  assign out_valid = (state_q == FULL);
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_rr_arb4way16.sv
// Self-checking bench for rr_arb4way16: directed steps followed by random
// traffic, compared against a behavioural round-robin model.
// Optional feature macro: RR_ARB4WAY16_LOCK_EN (enables the lock steps).
module tb_rr_arb4way16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [15:0] din [4];
  logic        out_ready;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
`ifdef RR_ARB4WAY16_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_valid;
  logic [15:0] m_data;
  int          m_sel;
  int          m_g;
  bit          m_lock;
  int          m_lidx;
  bit          m_last;

  rr_arb4way16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data_a (din[0]),
    .in_data_b (din[1]),
    .in_data_c (din[2]),
    .in_data_d (din[3]),
`ifdef RR_ARB4WAY16_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first valid index searching ptr, ptr+1, ... mod 4.
  function automatic int model_grant(logic [3:0] v);
    if (m_lock) return v[m_lidx] ? m_lidx : -1;
    for (int k = 0; k < 4; k++)
      if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  // One clock: check ready before the edge, update model on the edge, check outputs after.
  task automatic tick();
    bit         take;
    logic [3:0] er;
    #1;
    take = !m_valid || out_ready;
    m_g  = take ? model_grant(in_valid) : -1;
    er   = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
    chk("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    if (m_g >= 0) begin
      m_data  = din[m_g];
      m_sel   = m_g;
      m_valid = 1'b1;
`ifdef RR_ARB4WAY16_LOCK_EN
      m_last = in_last[m_g];
      if (in_last[m_g]) begin
        m_lock = 1'b0;
        m_ptr  = (m_g + 1) % 4;
      end else begin
        m_lock = 1'b1;
        m_lidx = m_g;
      end
`else
      m_ptr = (m_g + 1) % 4;
`endif
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
`ifdef RR_ARB4WAY16_LOCK_EN
    chk("out_last", 32'(out_last), 32'(m_last));
`endif
  endtask

  // Assert reset away from any clock edge, check immediate clearing, release on negedge.
  task automatic reset_check();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    m_valid = 1'b0; m_data = 16'h0; m_sel = 0; m_ptr = 0;
    m_lock = 1'b0; m_lidx = 0; m_last = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 16'h0;
`ifdef RR_ARB4WAY16_LOCK_EN
    in_last = 4'b1111;
`endif
    #2;
    reset_check();

    // Idle after reset
    for (int i = 0; i < 10; i++) tick();

    // Single requester c
    din[2] = 16'hBEEF;
    in_valid = 4'b0100;
    tick();
    chk("single_sel", 32'(out_sel), 32'd2);
    chk("single_data", 32'(out_data), 32'hBEEF);
    in_valid = 4'b0000;
    tick();

    // All four valid from ptr=0: order 0,1,2,3,0
    reset_check();
    for (int i = 0; i < 4; i++) din[i] = 16'(i + 1);
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_order", 32'(out_sel), 32'(i % 4));
      chk("rr_data", 32'(out_data), 32'((i % 4) + 1));
    end

    // Backpressure: hold five cycles, then drain and refill on one edge
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'h1);
      chk("bp_hold_sel", 32'(out_sel), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    chk("refill_valid", 32'(out_valid), 32'd1);
    chk("refill_sel", 32'(out_sel), 32'd1);

    // Pointer wrap: grant 3, then 1001 must pick 0
    in_valid = 4'b0000;
    tick();
    reset_check();
    in_valid = 4'b1000;
    tick();
    chk("wrap_first", 32'(out_sel), 32'd3);
    in_valid = 4'b1001;
    tick();
    chk("wrap_next", 32'(out_sel), 32'd0);

    // Async reset while full; first grant afterwards is lowest valid index
    in_valid = 4'b1111;
    reset_check();
    in_valid = 4'b1010;
    tick();
    chk("post_rst_sel", 32'(out_sel), 32'd1);

`ifdef RR_ARB4WAY16_LOCK_EN
    // Lock: requester 1 sends three beats while requester 2 waits
    in_valid = 4'b0000;
    tick();
    reset_check();
    in_valid = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2) ? 4'b0110 : 4'b0100;
      tick();
      chk("lock_sel", 32'(out_sel), (i < 3) ? 32'd1 : 32'd2);
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom);
      for (int j = 0; j < 4; j++) din[j] = 16'($urandom);
      out_ready = ($urandom % 4) != 0;
`ifdef RR_ARB4WAY16_LOCK_EN
      in_last = 4'($urandom);
`endif
      tick();
    end

    in_valid = 4'b0000;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
